// File: rtl/except_ctrl.sv
// -----------------------------------------------------------------------------
// except_ctrl
//
// MEM-stage exception arbitration and commit controller sitting in front of
// cp0_reg. It synchronizes the external interrupt lines and decides whether
// the instruction in MEM takes an interrupt or exception. It emits one
// exception code per taken exception, together with the pipeline flush and
// the redirect PC. An exception found while MEM is stalled is held and
// committed on the first unstalled cycle.
//
// Parameters
//   EXC_VECTOR   redirect target for every exception and interrupt
//   SYNC_STAGES  depth of the ext_int synchronizer (2 or 3)
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   ext_int[5:0]              raw asynchronous hardware interrupt lines
//   timer_int_i               CP0 timer interrupt, ORed into IP7
//   valid_m, stall_m          MEM holds a real instruction / MEM is stalled
//   pc_m, is_in_delayslot_m   MEM instruction address and delay-slot flag
//   exc_flags_m[7:0]          {eret, ades, adel_ld, ov, brk, sys, ri, adel_if}
//   data_addr_m               load/store effective address
//   status_i, cause_i, epc_i  CP0 register values
//   cp0_we_w/_waddr_w/_wdata_w  WB-stage mtc0 write, bypassed into the CP0 view
//   int_o[5:0]                synchronized interrupt lines to CP0
//   excepttype_o              committed exception code, 0 when none
//   bad_addr_o, pc_o, delayslot_o  details of the committed exception
//   flush_o, newpc_o          flush IF..MEM and redirect target
// -----------------------------------------------------------------------------
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        timer_int_i,
  input  logic        valid_m,
  input  logic        stall_m,
  input  logic [31:0] pc_m,
  input  logic        is_in_delayslot_m,
  input  logic [7:0]  exc_flags_m,
  input  logic [31:0] data_addr_m,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        cp0_we_w,
  input  logic [4:0]  cp0_waddr_w,
  input  logic [31:0] cp0_wdata_w,
  output logic [5:0]  int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] bad_addr_o,
  output logic [31:0] pc_o,
  output logic        delayslot_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  localparam logic [4:0] CODE_INT  = 5'h01;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0A;
  localparam logic [4:0] CODE_OV   = 5'h0C;
  localparam logic [4:0] CODE_ERET = 5'h0E;

  // ---------------------------------------------------------------------------
  // ext_int synchronizer: one register per stage, stage 0 samples the pins.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [5:0] stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage_reg <= 6'd0;
          else      stage_reg <= ext_int;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage_reg <= 6'd0;
          else      stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign int_o = g_sync[SYNC_STAGES-1].stage_reg;

  // ---------------------------------------------------------------------------
  // CP0 view with the WB-stage mtc0 forwarded, so an instruction in MEM sees
  // the Status/Cause/EPC value that is about to be written.
  // ---------------------------------------------------------------------------
  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;

  assign status_eff = (cp0_we_w && cp0_waddr_w == 5'd12) ? cp0_wdata_w : status_i;
  assign cause_eff  = (cp0_we_w && cp0_waddr_w == 5'd13) ? cp0_wdata_w : cause_i;
  assign epc_eff    = (cp0_we_w && cp0_waddr_w == 5'd14) ? cp0_wdata_w : epc_i;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:10], cause_eff[7:0]};

  // Interrupts are enabled only with IE=1 and EXL=0; IP7 also carries the timer.
  logic [7:0] ip;
  logic       int_req;

  assign ip      = {int_o[5] | timer_int_i, int_o[4:0], cause_eff[9:8]};
  assign int_req = status_eff[0] & ~status_eff[1] & (|(ip & status_eff[15:8]));

  // ---------------------------------------------------------------------------
  // Priority encoder over the flags carried down the pipeline.
  // ---------------------------------------------------------------------------
  logic f_eret, f_ades, f_adel_ld, f_ov, f_brk, f_sys, f_ri, f_adel_if;
  assign {f_eret, f_ades, f_adel_ld, f_ov, f_brk, f_sys, f_ri, f_adel_if} = exc_flags_m;

  logic [4:0]  det_code;
  logic [31:0] det_bad;

  always_comb begin
    det_code = 5'd0;
    det_bad  = 32'd0;
    if (valid_m) begin
      if (int_req) begin
        det_code = CODE_INT;
      end else if (f_adel_if) begin
        det_code = CODE_ADEL;
        det_bad  = pc_m;
      end else if (f_ri) begin
        det_code = CODE_RI;
      end else if (f_sys) begin
        det_code = CODE_SYS;
      end else if (f_brk) begin
        det_code = CODE_BP;
      end else if (f_ov) begin
        det_code = CODE_OV;
      end else if (f_adel_ld) begin
        det_code = CODE_ADEL;
        det_bad  = data_addr_m;
      end else if (f_ades) begin
        det_code = CODE_ADES;
        det_bad  = data_addr_m;
      end else if (f_eret) begin
        det_code = CODE_ERET;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and the exception captured during a stall.
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [4:0]  held_code_reg;
  logic [31:0] held_bad_reg;
  logic [31:0] held_pc_reg;
  logic        held_ds_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      held_code_reg <= 5'd0;
      held_bad_reg  <= 32'd0;
      held_pc_reg   <= 32'd0;
      held_ds_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (det_code != 5'd0) begin
            if (stall_m) begin
              // Freeze the decision now; it is not re-arbitrated later, so an
              // interrupt that drops during the stall is still taken.
              held_code_reg <= det_code;
              held_bad_reg  <= det_bad;
              held_pc_reg   <= pc_m;
              held_ds_reg   <= is_in_delayslot_m;
              state_reg     <= HOLD;
            end else begin
              state_reg <= FLUSH;
            end
          end
        end
        HOLD: begin
          if (!stall_m) state_reg <= FLUSH;
        end
        FLUSH: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Commit is combinational so CP0 captures it on the same edge that retires
  // the MEM instruction. FLUSH always reads as no-commit, which also keeps two
  // back-to-back commits impossible. Reset forces everything quiet at once.
  // ---------------------------------------------------------------------------
  logic        commit_valid;
  logic [4:0]  commit_code;
  logic [31:0] commit_bad;
  logic [31:0] commit_pc;
  logic        commit_ds;

  always_comb begin
    commit_valid = 1'b0;
    commit_code  = 5'd0;
    commit_bad   = 32'd0;
    commit_pc    = 32'd0;
    commit_ds    = 1'b0;
    if (rst) begin
      case (state_reg)
        IDLE: begin
          if (det_code != 5'd0 && !stall_m) begin
            commit_valid = 1'b1;
            commit_code  = det_code;
            commit_bad   = det_bad;
            commit_pc    = pc_m;
            commit_ds    = is_in_delayslot_m;
          end
        end
        HOLD: begin
          if (!stall_m) begin
            commit_valid = 1'b1;
            commit_code  = held_code_reg;
            commit_bad   = held_bad_reg;
            commit_pc    = held_pc_reg;
            commit_ds    = held_ds_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign excepttype_o = {27'd0, commit_code};
  assign bad_addr_o   = commit_bad;
  assign pc_o         = commit_pc;
  assign delayslot_o  = commit_ds;
  assign flush_o      = commit_valid;
  assign newpc_o      = !commit_valid ? 32'd0 :
                        (commit_code == CODE_ERET) ? epc_eff : EXC_VECTOR;

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;

  localparam int          SYNC = 2;
  localparam logic [31:0] VEC  = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  ext_int;
  logic        timer_int_i;
  logic        valid_m;
  logic        stall_m;
  logic [31:0] pc_m;
  logic        is_in_delayslot_m;
  logic [7:0]  exc_flags_m;
  logic [31:0] data_addr_m;
  logic [31:0] status_i, cause_i, epc_i;
  logic        cp0_we_w;
  logic [4:0]  cp0_waddr_w;
  logic [31:0] cp0_wdata_w;
  logic [5:0]  int_o;
  logic [31:0] excepttype_o, bad_addr_o, pc_o, newpc_o;
  logic        delayslot_o, flush_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  except_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .timer_int_i(timer_int_i),
    .valid_m(valid_m), .stall_m(stall_m), .pc_m(pc_m),
    .is_in_delayslot_m(is_in_delayslot_m), .exc_flags_m(exc_flags_m),
    .data_addr_m(data_addr_m), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .cp0_we_w(cp0_we_w), .cp0_waddr_w(cp0_waddr_w),
    .cp0_wdata_w(cp0_wdata_w), .int_o(int_o), .excepttype_o(excepttype_o),
    .bad_addr_o(bad_addr_o), .pc_o(pc_o), .delayslot_o(delayslot_o),
    .flush_o(flush_o), .newpc_o(newpc_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ext_int = 6'd0; timer_int_i = 1'b0; valid_m = 1'b0; stall_m = 1'b0;
    pc_m = 32'd0; is_in_delayslot_m = 1'b0; exc_flags_m = 8'd0;
    data_addr_m = 32'd0; status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0;
    cp0_we_w = 1'b0; cp0_waddr_w = 5'd0; cp0_wdata_w = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: exceptions rank by flag bit position (adel_if lowest bit,
  // highest priority), interrupts beat all flags. A stalled exception waits in
  // a one-entry pending slot; every commit is followed by one quiet cycle.
  // ---------------------------------------------------------------------------
  logic [4:0] prio_code [8] = '{5'h4, 5'hA, 5'h8, 5'h9, 5'hC, 5'h4, 5'h5, 5'hE};

  logic [5:0]  hist [3];
  bit          m_pend, n_pend, m_quiet, n_quiet;
  logic [4:0]  m_pcode, n_pcode;
  logic [31:0] m_pbad, n_pbad, m_ppc, n_ppc;
  bit          m_pds, n_pds;
  logic [31:0] e_code, e_bad, e_pc, e_newpc;
  logic        e_ds, e_flush;
  logic [5:0]  e_int;
  bit          prev_nz;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = 6'd0;
    m_pend = 0; m_quiet = 0; m_pcode = 0; m_pbad = 0; m_ppc = 0; m_pds = 0;
    prev_nz = 0;
  endtask

  task automatic model_eval();
    logic [31:0] st, ca, ep, db, cb, cp;
    logic [7:0]  ip;
    logic [4:0]  dc, cc;
    bit          ireq, found, take, cd;
    st = (cp0_we_w && cp0_waddr_w == 5'd12) ? cp0_wdata_w : status_i;
    ca = (cp0_we_w && cp0_waddr_w == 5'd13) ? cp0_wdata_w : cause_i;
    ep = (cp0_we_w && cp0_waddr_w == 5'd14) ? cp0_wdata_w : epc_i;
    e_int = hist[SYNC-1];
    ip = {e_int[5] | timer_int_i, e_int[4:0], ca[9:8]};
    ireq = st[0] && !st[1] && ((ip & st[15:8]) != 8'd0);
    dc = 0; db = 0; found = 0;
    if (ireq) begin
      dc = 5'h1; found = 1;
    end
    for (int b = 0; b < 8; b++) begin
      if (!found && exc_flags_m[b]) begin
        found = 1;
        dc = prio_code[b];
        db = (b == 0) ? pc_m : ((b == 5 || b == 6) ? data_addr_m : 32'd0);
      end
    end
    if (!valid_m) begin
      dc = 0; db = 0;
    end
    n_pend = m_pend; n_pcode = m_pcode; n_pbad = m_pbad; n_ppc = m_ppc; n_pds = m_pds;
    n_quiet = 0;
    take = 0; cc = 0; cb = 0; cp = 0; cd = 0;
    if (m_quiet) begin
      take = 0;
    end else if (m_pend) begin
      if (!stall_m) begin
        take = 1; cc = m_pcode; cb = m_pbad; cp = m_ppc; cd = m_pds;
        n_pend = 0;
      end
    end else if (dc != 0) begin
      if (!stall_m) begin
        take = 1; cc = dc; cb = db; cp = pc_m; cd = is_in_delayslot_m;
      end else begin
        n_pend = 1; n_pcode = dc; n_pbad = db; n_ppc = pc_m; n_pds = is_in_delayslot_m;
      end
    end
    if (take) n_quiet = 1;
    e_code  = {27'd0, cc};
    e_bad   = cb;
    e_pc    = cp;
    e_ds    = cd;
    e_flush = take;
    e_newpc = !take ? 32'd0 : ((cc == 5'hE) ? ep : VEC);
  endtask

  task automatic rcycle(input int n);
    bit nz;
    @(negedge clk);
    model_eval();
    chk($sformatf("rnd%0d_code", n), excepttype_o, e_code);
    chk($sformatf("rnd%0d_bad", n), bad_addr_o, e_bad);
    chk($sformatf("rnd%0d_pc", n), pc_o, e_pc);
    chk($sformatf("rnd%0d_ds", n), {31'd0, delayslot_o}, {31'd0, e_ds});
    chk($sformatf("rnd%0d_flush", n), {31'd0, flush_o}, {31'd0, e_flush});
    chk($sformatf("rnd%0d_newpc", n), newpc_o, e_newpc);
    chk($sformatf("rnd%0d_int", n), {26'd0, int_o}, {26'd0, e_int});
    nz = (excepttype_o != 32'd0);
    chk($sformatf("rnd%0d_single_cycle", n), {31'd0, prev_nz & nz}, 32'd0);
    prev_nz = nz;
    @(posedge clk);
    m_pend = n_pend; m_pcode = n_pcode; m_pbad = n_pbad; m_ppc = n_ppc; m_pds = n_pds;
    m_quiet = n_quiet;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = ext_int;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Single-cycle vectors, each applied from IDLE with no stall.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        valid;
    logic [7:0]  flags;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] daddr;
    logic [31:0] epc;
    logic [31:0] exp_code;
    logic [31:0] exp_bad;
    logic [31:0] exp_newpc;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b1, 8'h11, 32'h0, 32'h0, 32'h80000102, 1'b0, 32'h0, 32'h0, 32'h4, 32'h80000102, VEC};
    vecs[1]  = '{1'b1, 8'h0E, 32'h0, 32'h0, 32'h80000110, 1'b1, 32'h0, 32'h0, 32'hA, 32'h0, VEC};
    vecs[2]  = '{1'b1, 8'h0C, 32'h0, 32'h0, 32'h80000120, 1'b0, 32'h0, 32'h0, 32'h8, 32'h0, VEC};
    vecs[3]  = '{1'b1, 8'h18, 32'h0, 32'h0, 32'h80000130, 1'b1, 32'h0, 32'h0, 32'h9, 32'h0, VEC};
    vecs[4]  = '{1'b1, 8'h30, 32'h0, 32'h0, 32'h80000140, 1'b0, 32'h9000, 32'h0, 32'hC, 32'h0, VEC};
    vecs[5]  = '{1'b1, 8'h60, 32'h0, 32'h0, 32'h80000150, 1'b0, 32'h80001003, 32'h0, 32'h4, 32'h80001003, VEC};
    vecs[6]  = '{1'b1, 8'hC0, 32'h0, 32'h0, 32'h80000160, 1'b1, 32'h80002001, 32'h0, 32'h5, 32'h80002001, VEC};
    vecs[7]  = '{1'b1, 8'h80, 32'h0, 32'h0, 32'h80000170, 1'b0, 32'h0, 32'h80000500, 32'hE, 32'h0, 32'h80000500};
    vecs[8]  = '{1'b1, 8'h00, 32'h0, 32'h0, 32'h80000180, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 8'hFF, 32'h0, 32'h0, 32'h80000190, 1'b1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 8'h02, 32'h101, 32'h100, 32'h800001A0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h0, VEC};
    vecs[11] = '{1'b1, 8'h02, 32'h103, 32'h100, 32'h800001B0, 1'b0, 32'h0, 32'h0, 32'hA, 32'h0, VEC};
    vecs[12] = '{1'b0, 8'h00, 32'h101, 32'h100, 32'h800001C0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 8'h04, 32'h201, 32'h100, 32'h800001D0, 1'b0, 32'h0, 32'h0, 32'h8, 32'h0, VEC};
  end

  initial begin
    clear_inputs();
    rst = 1'b0;
    #1;
    // Reset state: inputs that would commit must be masked while in reset.
    valid_m = 1'b1; exc_flags_m = 8'h04; ext_int = 6'h3F;
    @(negedge clk);
    chk("reset_code", excepttype_o, 32'd0);
    chk("reset_flush", {31'd0, flush_o}, 32'd0);
    chk("reset_newpc", newpc_o, 32'd0);
    @(negedge clk);
    chk("reset_int", {26'd0, int_o}, 32'd0);
    do_reset();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 14; i++) begin
      valid_m = vecs[i].valid; exc_flags_m = vecs[i].flags; status_i = vecs[i].status;
      cause_i = vecs[i].cause; pc_m = vecs[i].pc; is_in_delayslot_m = vecs[i].ds;
      data_addr_m = vecs[i].daddr; epc_i = vecs[i].epc; stall_m = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_code", i), excepttype_o, vecs[i].exp_code);
      chk($sformatf("tbl%0d_bad", i), bad_addr_o, vecs[i].exp_bad);
      chk($sformatf("tbl%0d_newpc", i), newpc_o, vecs[i].exp_newpc);
      chk($sformatf("tbl%0d_flush", i), {31'd0, flush_o}, {31'd0, vecs[i].exp_code != 32'd0});
      chk($sformatf("tbl%0d_pc", i), pc_o, (vecs[i].exp_code != 32'd0) ? vecs[i].pc : 32'd0);
      chk($sformatf("tbl%0d_ds", i), {31'd0, delayslot_o},
          {31'd0, (vecs[i].exp_code != 32'd0) ? vecs[i].ds : 1'b0});
      tick();
      // Same inputs held: the cycle after a commit must be quiet.
      @(negedge clk);
      chk($sformatf("tbl%0d_quiet_code", i), excepttype_o, 32'd0);
      chk($sformatf("tbl%0d_quiet_flush", i), {31'd0, flush_o}, 32'd0);
      tick();
    end
    clear_inputs();
    tick();

    // ---------------- external interrupt through synchronizer ----------------
    status_i = 32'h0000_0401; ext_int = 6'b000001; valid_m = 1'b0;
    @(negedge clk);
    chk("int_sync0", {26'd0, int_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("int_sync1", {26'd0, int_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("int_sync2", {26'd0, int_o}, 32'd1);
    chk("int_bubble_code", excepttype_o, 32'd0);
    tick();
    valid_m = 1'b1; pc_m = 32'h8000_0100;
    @(negedge clk);
    chk("int_code", excepttype_o, 32'd1);
    chk("int_newpc", newpc_o, VEC);
    chk("int_flush", {31'd0, flush_o}, 32'd1);
    chk("int_pc", pc_o, 32'h8000_0100);
    tick();
    @(negedge clk);
    chk("int_after_flush", {31'd0, flush_o}, 32'd0);
    chk("int_after_code", excepttype_o, 32'd0);
    clear_inputs();
    tick(); tick(); tick();

    // ---------------- ades held through a 3-cycle stall ----------------
    valid_m = 1'b1; exc_flags_m = 8'h40; data_addr_m = 32'h8000_2001;
    pc_m = 32'h8000_0200; is_in_delayslot_m = 1'b1; stall_m = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_code", s), excepttype_o, 32'd0);
      chk($sformatf("stall%0d_flush", s), {31'd0, flush_o}, 32'd0);
      tick();
      // Later stalled cycles no longer carry the flags; the latched one rules.
      exc_flags_m = 8'h00; valid_m = 1'b0; pc_m = 32'h8000_0300; data_addr_m = 32'h0;
    end
    stall_m = 1'b0;
    @(negedge clk);
    chk("held_code", excepttype_o, 32'd5);
    chk("held_bad", bad_addr_o, 32'h8000_2001);
    chk("held_pc", pc_o, 32'h8000_0200);
    chk("held_ds", {31'd0, delayslot_o}, 32'd1);
    chk("held_flush", {31'd0, flush_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("held_once", excepttype_o, 32'd0);
    tick();

    // ---------------- eret with EPC forwarded from WB ----------------
    clear_inputs();
    valid_m = 1'b1; exc_flags_m = 8'h80; epc_i = 32'h0000_1234;
    cp0_we_w = 1'b1; cp0_waddr_w = 5'd14; cp0_wdata_w = 32'h8000_0400;
    @(negedge clk);
    chk("eret_code", excepttype_o, 32'hE);
    chk("eret_newpc", newpc_o, 32'h8000_0400);
    tick();
    clear_inputs();
    tick();

    // ---------------- EXL blocks interrupt, then syscall ----------------
    status_i = 32'h0000_0103; cause_i = 32'h0000_0100; valid_m = 1'b1;
    @(negedge clk);
    chk("exl_code", excepttype_o, 32'd0);
    chk("exl_flush", {31'd0, flush_o}, 32'd0);
    tick();
    exc_flags_m = 8'h04;
    @(negedge clk);
    chk("exl_sys_code", excepttype_o, 32'd8);
    tick();
    clear_inputs();
    tick();

    // ---------------- reset asserted during HOLD ----------------
    valid_m = 1'b1; exc_flags_m = 8'h04; stall_m = 1'b1; pc_m = 32'h8000_0600;
    @(negedge clk);
    chk("rsthold_stalled", excepttype_o, 32'd0);
    tick();
    stall_m = 1'b0; valid_m = 1'b0; exc_flags_m = 8'h00;
    #1;
    chk("rsthold_pre", excepttype_o, 32'd8);
    rst = 1'b0;
    #1;
    chk("rsthold_code", excepttype_o, 32'd0);
    chk("rsthold_flush", {31'd0, flush_o}, 32'd0);
    chk("rsthold_newpc", newpc_o, 32'd0);
    tick();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk($sformatf("rsthold_after%0d", s), excepttype_o, 32'd0);
      tick();
    end

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int n = 0; n < 600; n++) begin
      valid_m = ($urandom % 4) != 0;
      stall_m = ($urandom % 10) < 3;
      pc_m = $urandom;
      is_in_delayslot_m = 1'($urandom % 2);
      case ($urandom % 4)
        0: exc_flags_m = 8'd0;
        1: exc_flags_m = 8'd1 << ($urandom % 8);
        2: exc_flags_m = 8'($urandom);
        default: exc_flags_m = 8'd0;
      endcase
      data_addr_m = $urandom;
      status_i = {16'd0, 8'($urandom), 6'd0, 1'(($urandom % 5) == 0), 1'(($urandom % 10) < 7)};
      cause_i = $urandom;
      epc_i = $urandom;
      if (($urandom % 8) == 0) ext_int = 6'($urandom);
      timer_int_i = ($urandom % 16) == 0;
      cp0_we_w = ($urandom % 4) == 0;
      cp0_waddr_w = 5'(12 + ($urandom % 4));
      cp0_wdata_w = $urandom;
      rcycle(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
